// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned FWD_W = 2;
   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } state_t;

   localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

   // A producer matches a consumer only if it writes a non-zero register.
   function automatic logic reg_match(input logic             wen,
                                      input logic [REG_W-1:0] wr,
                                      input logic [REG_W-1:0] src);
      return wen && (wr != '0) && (wr == src);
   endfunction

endpackage

// File: rtl/forward_unit.sv
// ALU operand forwarding select for one EX source register.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] src_ex,
   input  logic             reg_write_mem,
   input  logic [REG_W-1:0] write_reg_mem,
   input  logic             reg_write_wb,
   input  logic [REG_W-1:0] write_reg_wb,
   output logic [FWD_W-1:0] fwd_sel_c
);

   // MEM holds the younger result, so it wins over WB.
   always_comb begin
      fwd_sel_c = FWD_REG;
      if (reg_match(reg_write_mem, write_reg_mem, src_ex)) begin
         fwd_sel_c = FWD_MEM;
      end else if (reg_match(reg_write_wb, write_reg_wb, src_ex)) begin
         fwd_sel_c = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch/jump flush and forwarding control for a 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] Rs_ID,
   input  logic [REG_W-1:0] Rt_ID,
   input  logic             Jump_ID,
   input  logic [REG_W-1:0] Rs_EX,
   input  logic [REG_W-1:0] Rt_EX,
   input  logic             MemRead_EX,
   input  logic             RegWrite_EX,
   input  logic [REG_W-1:0] Write_register_EX,
   input  logic             RegWrite_MEM,
   input  logic [REG_W-1:0] Write_register_MEM,
   input  logic             RegWrite_WB,
   input  logic [REG_W-1:0] Write_register_WB,
   input  logic             Branch_taken_EX,
   output logic             Stall_PC,
   output logic             Stall_IFID,
   output logic             Flush_IFID,
   output logic             Flush_IDEX,
   output logic [FWD_W-1:0] ForwardA_EX,
   output logic [FWD_W-1:0] ForwardB_EX
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] Stall_cnt,
   output logic [CNT_W-1:0] Flush_cnt
`endif
);

   state_t           state;
   state_t           state_nxt;
   logic             load_use_c;
   logic [FWD_W-1:0] fwd_a_c;
   logic [FWD_W-1:0] fwd_b_c;
   logic             unused_regwrite_ex;

   // A load always writes, so the load-use test keys on MemRead alone.
   assign unused_regwrite_ex = RegWrite_EX;

   assign load_use_c = MemRead_EX &&
                       (reg_match(1'b1, Write_register_EX, Rs_ID) ||
                        reg_match(1'b1, Write_register_EX, Rt_ID));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Priority: taken branch, then load-use stall, then jump flush.
   always_comb begin
      state_nxt  = RUN;
      Stall_PC   = 1'b0;
      Stall_IFID = 1'b0;
      Flush_IFID = 1'b0;
      Flush_IDEX = 1'b0;
      if (reset) begin
         if (Branch_taken_EX) begin
            Flush_IFID = 1'b1;
            Flush_IDEX = 1'b1;
         end else if ((state == RUN) && load_use_c) begin
            Stall_PC   = 1'b1;
            Stall_IFID = 1'b1;
            Flush_IDEX = 1'b1;
            state_nxt  = BUBBLE;
         end else if (Jump_ID) begin
            Flush_IFID = 1'b1;
         end
      end
   end

   forward_unit u_fwd_a (
      .src_ex        (Rs_EX),
      .reg_write_mem (RegWrite_MEM),
      .write_reg_mem (Write_register_MEM),
      .reg_write_wb  (RegWrite_WB),
      .write_reg_wb  (Write_register_WB),
      .fwd_sel_c     (fwd_a_c)
   );

   forward_unit u_fwd_b (
      .src_ex        (Rt_EX),
      .reg_write_mem (RegWrite_MEM),
      .write_reg_mem (Write_register_MEM),
      .reg_write_wb  (RegWrite_WB),
      .write_reg_wb  (Write_register_WB),
      .fwd_sel_c     (fwd_b_c)
   );

   assign ForwardA_EX = reset ? fwd_a_c : FWD_REG;
   assign ForwardB_EX = reset ? fwd_b_c : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         Stall_cnt <= '0;
         Flush_cnt <= '0;
      end else begin
         if (Stall_PC) begin
            Stall_cnt <= Stall_cnt + CNT_W'(1);
         end
         if (Flush_IFID || Flush_IDEX) begin
            Flush_cnt <= Flush_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
